// File: rtl/mux_arb8_pkg.sv
// Shared constants, FSM state type and round-robin search for mux_arb8.
// Latency: none, pure declarations and a combinational helper; backpressure: n/a.
package mux_arb8_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Walk from ptr+8 (ptr itself, lowest priority) down to ptr+1 so the
  // last hit wins, giving ptr+1 the highest priority.
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr,
                                               input logic [NCH-1:0]   req);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] res;
    res = ptr;
    for (int k = NCH; k >= 1; k--) begin
      idx = ptr + k[SEL_W-1:0];
      if (req[idx]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_arb8_rr_arb8.sv
// Combinational round-robin picker over eight requests, starting after ptr.
// Latency: 0 cycles; backpressure: none, the caller decides whether to use the grant.
module rr_arb8
  import mux_arb8_pkg::*;
(
  input  logic [SEL_W-1:0] ptr,
  input  logic [NCH-1:0]   req,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  assign gnt_idx = rr_next(ptr, req);
  assign gnt_any = |req;

endmodule

// File: rtl/mux_arb8.sv
// 8:1 round-robin mux into a registered output slot; MUX_ARB8_PARITY_EN adds y_par.
// Latency: 1 cycle req->y_vld; backpressure: y/s held and no ch_ack while y_vld && !y_rdy.
module mux_arb8
  import mux_arb8_pkg::*;
#(
  parameter int W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   ch_req,
  input  logic [NCH*W-1:0] ch_data,
  output logic [NCH-1:0]   ch_ack,
  output logic [W-1:0]     y,
  output logic [SEL_W-1:0] s,
  output logic             y_vld,
`ifdef MUX_ARB8_PARITY_EN
  output logic             y_par,
`endif
  input  logic             y_rdy
);

  state_t           r_state;
  logic [W-1:0]     r_y;
  logic [SEL_W-1:0] r_s;
  logic [SEL_W-1:0] r_ptr;

  logic [SEL_W-1:0] w_gnt_idx;
  logic             w_gnt_any;
  logic             w_free;
  logic             w_cap;
  logic [W-1:0]     w_sel_dat;

  rr_arb8 u_arb (
    .ptr     (r_ptr),
    .req     (ch_req),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_gnt_any)
  );

  // Gating with rst_n keeps ch_ack low while reset is held, so the first
  // capture can only happen on the first edge after release.
  assign w_free    = rst_n && ((r_state == IDLE) || y_rdy);
  assign w_cap     = w_free && w_gnt_any;
  assign w_sel_dat = ch_data[w_gnt_idx*W +: W];
  assign ch_ack    = w_cap ? ({{(NCH-1){1'b0}}, 1'b1} << w_gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_y     <= '0;
      r_s     <= '0;
      r_ptr   <= SEL_W'(NCH - 1);
    end else if (w_cap) begin
      r_state <= HOLD;
      r_y     <= w_sel_dat;
      r_s     <= w_gnt_idx;
      r_ptr   <= w_gnt_idx;
    end else if (w_free) begin
      r_state <= IDLE;
    end
  end

`ifdef MUX_ARB8_PARITY_EN
  logic r_par;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (w_cap) begin
      r_par <= ^w_sel_dat;
    end
  end

  assign y_par = r_par;
`endif

  assign y     = r_y;
  assign s     = r_s;
  assign y_vld = (r_state == HOLD);

endmodule
